// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, one-entry output buffer.
// Latency: request in REQ, response no earlier than next cycle, entry visible the cycle after the response.
// Backpressure: pc_write=0 holds the buffered entry and blocks further requests; redirect overrides a stall.
//
// Ports:
//   clock, reset              - single clock, async active-high reset
//   pc_write                  - hazard-unit enable (0 = stall), shared with the IF_ID write enable
//   redirect_valid/_pc        - taken branch/jump and its target (low two bits ignored)
//   imem_req_valid/_ready/_addr - instruction-memory request handshake, address = current PC
//   imem_rsp_valid/_data      - instruction-memory response
//   out_valid/_pc/_pc_plus4/_instr - buffered instruction presented to IF_ID (NOP when empty)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        buf_ld;
  logic [31:0] buf_pc, buf_pc4, buf_instr;
  logic [31:0] target;

  assign target = {redirect_pc[31:2], 2'b00};

  // Next-state logic. kill marks a request whose response must be thrown
  // away because a redirect arrived while it was in flight.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    buf_ld    = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = target;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = target;
          if (imem_rsp_valid) begin
            // Response for the old path lands in the same cycle: drop it now.
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            kill_nxt = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            buf_ld    = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (pc_write) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
    end
  end

  // pc+4 is registered alongside the buffer so the outputs carry no
  // arithmetic and the reset value can be zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_pc    <= 32'd0;
      buf_pc4   <= 32'd0;
      buf_instr <= NOP;
    end else if (buf_ld) begin
      buf_pc    <= pc;
      buf_pc4   <= pc + 32'd4;
      buf_instr <= imem_rsp_data;
    end
  end

  // Request strobe is masked during reset since the state register already
  // reads REQ while reset is held.
  assign imem_req_valid = (state == S_REQ) && !redirect_valid && !reset;
  assign imem_req_addr  = pc;
  assign out_valid      = (state == S_HOLD);
  assign out_pc         = buf_pc;
  assign out_pc_plus4   = buf_pc4;
  assign out_instr      = out_valid ? buf_instr : NOP;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_pc, out_pc_plus4, out_instr;

  logic        w_req_valid, w_out_valid;
  logic [31:0] w_req_addr, w_out_pc, w_out_pc_plus4, w_out_instr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  if_stage dut (
    .clock(clock), .reset(reset), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr)
  );

  // Second instance starting at the top of the address space to observe wrap.
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(w_out_valid), .out_pc(w_out_pc),
    .out_pc_plus4(w_out_pc_plus4), .out_instr(w_out_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Advance to the next low phase, where the bench drives inputs.
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [31:0] model_pc, pend_addr, tgt;
  bit          outstanding, rv, rsp;
  int          delivered;

  initial begin
    reset = 1'b1; pc_write = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc4", out_pc_plus4, 32'd0);
    chk("rst_out_instr", out_instr, NOP);

    // Basic fetch with 1-cycle memory
    reset = 1'b0; imem_req_ready = 1'b1; pc_write = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'd0);
    chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
    tick;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    #1;
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("no_comb_rsp_path", {31'd0, out_valid}, 32'd0);
    tick;
    imem_rsp_valid = 1'b0;
    #1;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_pc", out_pc, 32'd0);
    chk("hold_pc4", out_pc_plus4, 32'd4);
    chk("hold_instr", out_instr, 32'h0050_0093);
    chk("wrap_pc4", w_out_pc_plus4, 32'd0);
    tick;
    #1;
    chk("consumed_valid", {31'd0, out_valid}, 32'd0);
    chk("consumed_nop", out_instr, NOP);
    chk("second_req_addr", imem_req_addr, 32'd4);
    chk("wrap_second_addr", w_req_addr, 32'd0);

    // Stall in HOLD for 5 cycles, with stray response strobes
    tick;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0113; pc_write = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = (i % 2 == 0); imem_rsp_data = 32'hDEAD_BEEF;
      #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, 32'd4);
      chk("stall_instr", out_instr, 32'h00A0_0113);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick;
    end
    imem_rsp_valid = 1'b0; pc_write = 1'b1;
    tick;
    #1;
    chk("post_stall_addr", imem_req_addr, 32'd8);

    // Redirect in WAIT at pc 0x8, response arrives later and is dropped
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    #1;
    chk("kill_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick;
    imem_rsp_valid = 1'b0;
    #1;
    chk("kill_dropped", {31'd0, out_valid}, 32'd0);
    chk("kill_next_addr", imem_req_addr, 32'h0000_0100);

    // Redirect coinciding with the WAIT response, unaligned target
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
    tick;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("coinc_dropped", {31'd0, out_valid}, 32'd0);
    chk("coinc_next_addr", imem_req_addr, 32'h0000_0200);

    // Reach HOLD at 0x40 then pulse reset asynchronously
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; imem_rsp_valid = 1'b1;
    tick;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    tick;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333; pc_write = 1'b0;
    tick;
    imem_rsp_valid = 1'b0;
    #1;
    chk("hold40_valid", {31'd0, out_valid}, 32'd1);
    chk("hold40_pc", out_pc, 32'h0000_0040);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_instr", out_instr, NOP);
    imem_req_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("after_rst_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("after_rst_addr", imem_req_addr, 32'd0);

    // Randomized traffic against a transaction-level model: delivered PCs
    // follow program order, restarting at each redirect target.
    model_pc = 32'd0; outstanding = 1'b0; pend_addr = 32'd0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rv = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else tgt = $urandom & 32'h0000_0FFF;
      redirect_valid = rv; redirect_pc = tgt;
      pc_write = ($urandom_range(3) != 0);
      imem_req_ready = $urandom_range(1);
      if (outstanding) begin
        rsp = $urandom_range(1); imem_rsp_data = mem_word(pend_addr);
      end else begin
        rsp = ($urandom_range(7) == 0); imem_rsp_data = $urandom;
      end
      imem_rsp_valid = rsp;
      #1;
      chk("rnd_req_valid", {31'd0, imem_req_valid}, {31'd0, !rv && !outstanding && !out_valid});
      if (imem_req_valid) chk("rnd_req_addr", imem_req_addr, model_pc);
      if (out_valid) begin
        chk("rnd_out_pc", out_pc, model_pc);
        chk("rnd_out_pc4", out_pc_plus4, model_pc + 32'd4);
        chk("rnd_out_instr", out_instr, mem_word(model_pc));
      end else begin
        chk("rnd_idle_nop", out_instr, NOP);
      end
      if (rsp && outstanding) outstanding = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        outstanding = 1'b1; pend_addr = model_pc;
      end
      if (rv) model_pc = tgt & 32'hFFFF_FFFC;
      else if (out_valid && pc_write) begin
        model_pc = model_pc + 32'd4; delivered++;
      end
    end
    chk("rnd_progress", {31'd0, delivered > 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
